// File: rtl/video_timing_sched.sv
// Programmable raster timing scheduler: pixel/line counters, vertical phase FSM and registered sync outputs.
// Optional build macro VTG_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
//
// state  | meaning
// V_ACT  | active video lines
// V_FP   | vertical front porch lines
// V_SYNC | vertical sync lines (vsync high)
// V_BP   | vertical back porch lines; frame ends on its last pixel
module video_timing_sched #(
  parameter int CW       = 12,
  parameter int H_ACT_D  = 640,
  parameter int H_FP_D   = 16,
  parameter int H_SYNC_D = 96,
  parameter int H_BP_D   = 48,
  parameter int V_ACT_D  = 480,
  parameter int V_FP_D   = 10,
  parameter int V_SYNC_D = 2,
  parameter int V_BP_D   = 33
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          en,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_pending,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int HW = CW + 2;

  typedef enum logic [1:0] {
    V_ACT  = 2'd0,
    V_FP   = 2'd1,
    V_SYNC = 2'd2,
    V_BP   = 2'd3
  } vstate_t;

  function automatic logic [CW-1:0] dflt(input int idx);
    case (idx)
      0:       return CW'(H_ACT_D);
      1:       return CW'(H_FP_D);
      2:       return CW'(H_SYNC_D);
      3:       return CW'(H_BP_D);
      4:       return CW'(V_ACT_D);
      5:       return CW'(V_FP_D);
      6:       return CW'(V_SYNC_D);
      default: return CW'(V_BP_D);
    endcase
  endfunction

  // A zero-length phase would stall the sequencer, so it is stretched to one.
  function automatic logic [CW-1:0] nz(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  logic [CW-1:0] act_q [8];
  logic [CW-1:0] shd_q [8];
  logic          pend_q;

  logic [CW-1:0] h_act, h_fp, h_sync, h_bp;
  logic [CW-1:0] v_act, v_fp, v_sync, v_bp;
  logic [HW-1:0] hs_beg, hs_end, htot;

  assign h_act  = nz(act_q[0]);
  assign h_fp   = nz(act_q[1]);
  assign h_sync = nz(act_q[2]);
  assign h_bp   = nz(act_q[3]);
  assign v_act  = nz(act_q[4]);
  assign v_fp   = nz(act_q[5]);
  assign v_sync = nz(act_q[6]);
  assign v_bp   = nz(act_q[7]);

  assign hs_beg = HW'(h_act) + HW'(h_fp);
  assign hs_end = hs_beg + HW'(h_sync);
  assign htot   = hs_end + HW'(h_bp);

  vstate_t       state_q, state_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [CW-1:0] phase_len;
  logic          phase_last;
  logic          eol;
  logic          frame_end;

  assign eol = (hpos_q >= htot - 1'b1);

  always_comb begin
    phase_len = v_act;
    case (state_q)
      V_ACT:   phase_len = v_act;
      V_FP:    phase_len = v_fp;
      V_SYNC:  phase_len = v_sync;
      V_BP:    phase_len = v_bp;
      default: phase_len = v_act;
    endcase
  end

  assign phase_last = (lcnt_q == phase_len - 1'b1);
  assign frame_end  = en && eol && (state_q == V_BP) && phase_last;

  always_comb begin
    state_d = state_q;
    hpos_d  = hpos_q + 1'b1;
    vpos_d  = vpos_q;
    lcnt_d  = lcnt_q;
    if (eol) begin
      hpos_d = '0;
      vpos_d = vpos_q + 1'b1;
      lcnt_d = lcnt_q + 1'b1;
      if (phase_last) begin
        lcnt_d = '0;
        case (state_q)
          V_ACT:  state_d = V_FP;
          V_FP:   state_d = V_SYNC;
          V_SYNC: state_d = V_BP;
          V_BP: begin
            state_d = V_ACT;
            vpos_d  = '0;
          end
          default: state_d = V_ACT;
        endcase
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q <= V_ACT;
      hpos_q  <= '0;
      vpos_q  <= '0;
      lcnt_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // The active set is loaded from the shadow as it stood before this cycle's write,
  // so a write landing on the frame-end cycle waits for the next frame end.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        act_q[i] <= dflt(i);
        shd_q[i] <= dflt(i);
      end
      pend_q <= 1'b0;
    end else begin
      if (frame_end) begin
        for (int i = 0; i < 8; i++) act_q[i] <= shd_q[i];
      end
      if (cfg_wr) begin
        shd_q[cfg_addr] <= cfg_data;
        pend_q          <= 1'b1;
      end else if (frame_end) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign cfg_pending = pend_q;

  logic hb, hs, vb, vs;

  assign hb = (hpos_q >= HW'(h_act));
  assign hs = (hpos_q >= hs_beg) && (hpos_q < hs_end);
  assign vb = (state_q != V_ACT);
  assign vs = (state_q == V_SYNC);

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      csync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcnt        <= hpos_q[CW-1:0];
      vcnt        <= vpos_q;
      hsync       <= hs;
      vsync       <= vs;
      csync       <= hs ^ vs;
      hblank      <= hb;
      vblank      <= vb;
      de          <= !hb && !vb;
      line_start  <= (hpos_q == '0);
      frame_start <= (hpos_q == '0) && (vpos_q == '0);
    end else begin
      // Strobes are single pulses; a stalled pixel clock must not stretch them.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic first_q;

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      frame_cnt <= '0;
      first_q   <= 1'b1;
    end else if (en && (hpos_q == '0) && (vpos_q == '0)) begin
      if (!first_q) frame_cnt <= frame_cnt + 1'b1;
      first_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_sched.sv
// Directed bench for video_timing_sched using a small default raster (HTOT 12, VTOT 6).
module tb_video_timing_sched;

  localparam int CW = 12;

  logic          CK = 1'b0;
  logic          RST_N;
  logic          en;
  logic          cfg_wr;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_pending;
  logic [CW-1:0] hcnt, vcnt;
  logic          hsync, vsync, csync, hblank, vblank, de, line_start, frame_start;
`ifdef VTG_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  video_timing_sched #(
    .CW(CW), .H_ACT_D(6), .H_FP_D(2), .H_SYNC_D(3), .H_BP_D(1),
    .V_ACT_D(2), .V_FP_D(1), .V_SYNC_D(2), .V_BP_D(1)
  ) dut (
    .CK(CK), .RST_N(RST_N), .en(en),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_pending(cfg_pending), .hcnt(hcnt), .vcnt(vcnt),
    .hsync(hsync), .vsync(vsync), .csync(csync),
    .hblank(hblank), .vblank(vblank), .de(de),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 CK = ~CK;

  int n_chk = 0;
  int n_err = 0;
  int n_de, n_hs, n_vs, n_vb, n_cs, n_ls, n_fs;
  logic [15:0] vs_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_de = 0; n_hs = 0; n_vs = 0; n_vb = 0; n_cs = 0; n_ls = 0; n_fs = 0;
    vs_mask = '0;
  endtask

  task automatic tick();
    @(posedge CK); #1;
    if (de)          n_de++;
    if (hsync)       n_hs++;
    if (vblank)      n_vb++;
    if (csync)       n_cs++;
    if (line_start)  n_ls++;
    if (frame_start) n_fs++;
    if (vsync) begin
      n_vs++;
      vs_mask[vcnt[3:0]] = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [CW-1:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  logic [7:0] hs_tab1 = 8'b0110_0000;
  logic [7:0] hb_tab1 = 8'b1111_0000;
  logic [8:0] hs_tab2 = 9'b0_1110_0000;

  initial begin
    RST_N = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge CK);
    #1;
    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_de", de, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ls", line_start, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vblank", vblank, 0);
    check("rst_pending", cfg_pending, 0);

    // Frame 0 at default timing; the small test config is written into the shadow.
    RST_N = 1'b1; en = 1'b1;
    clear_stats();
    tick();
    check("f0_hcnt", hcnt, 0);
    check("f0_vcnt", vcnt, 0);
    check("f0_de", de, 1);
    check("f0_fs", frame_start, 1);
    check("f0_ls", line_start, 1);
    wr(3'd0, 12'd4);
    check("f0_pend_set", cfg_pending, 1);
    wr(3'd1, 12'd1); wr(3'd2, 12'd2); wr(3'd3, 12'd1);
    wr(3'd4, 12'd3); wr(3'd5, 12'd1); wr(3'd6, 12'd1); wr(3'd7, 12'd1);
    ticks(62);
    check("f0_pend_hold", cfg_pending, 1);
    tick();
    check("f0_pend_clr", cfg_pending, 0);
    check("f0_end_hcnt", hcnt, 11);
    check("f0_end_vcnt", vcnt, 5);
    check("f0_de_cnt", n_de, 12);
    check("f0_hs_cnt", n_hs, 18);
    check("f0_vs_cnt", n_vs, 24);
    check("f0_vs_lines", vs_mask, 16'h0018);
    check("f0_vb_cnt", n_vb, 48);
    check("f0_cs_cnt", n_cs, 30);
    check("f0_ls_cnt", n_ls, 6);
    check("f0_fs_cnt", n_fs, 1);

    // Frame 1: H=4,1,2,1 V=3,1,1,1; H_SYNC=3 written mid-frame.
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("f1_hcnt", hcnt, i);
      check("f1_hsync", hsync, hs_tab1[i]);
      check("f1_hblank", hblank, hb_tab1[i]);
    end
    wr(3'd2, 12'd3);
    check("f1_pend_set", cfg_pending, 1);
    ticks(38);
    check("f1_pend_hold", cfg_pending, 1);
    tick();
    check("f1_pend_clr", cfg_pending, 0);
    check("f1_end_hcnt", hcnt, 7);
    check("f1_end_vcnt", vcnt, 5);
    check("f1_de_cnt", n_de, 12);
    check("f1_hs_cnt", n_hs, 12);
    check("f1_vs_cnt", n_vs, 8);
    check("f1_vs_lines", vs_mask, 16'h0010);
    check("f1_cs_cnt", n_cs, 16);
    check("f1_ls_cnt", n_ls, 6);
    check("f1_fs_cnt", n_fs, 1);

    // Frame 2: HTOT 9 with 3-wide hsync; V_FP=0 written for the next frame.
    clear_stats();
    for (int i = 0; i < 9; i++) begin
      tick();
      check("f2_hsync", hsync, hs_tab2[i]);
    end
    check("f2_fs_first", n_fs, 1);
    wr(3'd5, 12'd0);
    ticks(44);
    check("f2_end_hcnt", hcnt, 8);
    check("f2_end_vcnt", vcnt, 5);
    check("f2_pend_clr", cfg_pending, 0);
    check("f2_hs_cnt", n_hs, 18);
    check("f2_de_cnt", n_de, 12);
    check("f2_ls_cnt", n_ls, 6);

    // Frame 3: zero front porch acts as one line; en stalled at hcnt=3.
    clear_stats();
    tick();
    check("f3_fs", frame_start, 1);
    ticks(3);
    check("f3_pre_hcnt", hcnt, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CK); #1;
      check("stall_hcnt", hcnt, 3);
      check("stall_vcnt", vcnt, 0);
      check("stall_de", de, 1);
      check("stall_ls", line_start, 0);
    end
    en = 1'b1;
    tick();
    check("resume_hcnt", hcnt, 4);
    ticks(49);
    check("f3_end_hcnt", hcnt, 8);
    check("f3_end_vcnt", vcnt, 5);
    check("f3_ls_cnt", n_ls, 6);
    check("f3_fs_cnt", n_fs, 1);
    check("f3_de_cnt", n_de, 12);
    check("f3_vb_cnt", n_vb, 27);
    check("f3_vs_lines", vs_mask, 16'h0010);

    // Frame 4: pending shadow write, then reset during vsync.
    clear_stats();
    tick();
    check("f4_fs", frame_start, 1);
    wr(3'd0, 12'd5);
    check("f4_pend_set", cfg_pending, 1);
    ticks(37);
    check("f4_vcnt", vcnt, 4);
    check("f4_vsync", vsync, 1);
    RST_N = 1'b0;
    @(posedge CK); #1;
    check("mid_rst_vsync", vsync, 0);
    check("mid_rst_hcnt", hcnt, 0);
    check("mid_rst_vcnt", vcnt, 0);
    check("mid_rst_pend", cfg_pending, 0);
    check("mid_rst_de", de, 0);

    RST_N = 1'b1;
    clear_stats();
    tick();
    check("r0_fs", frame_start, 1);
    check("r0_hcnt", hcnt, 0);
    ticks(71);
    check("r0_end_hcnt", hcnt, 11);
    check("r0_end_vcnt", vcnt, 5);
    check("r0_pend", cfg_pending, 0);
    check("r0_de_cnt", n_de, 12);
    check("r0_hs_cnt", n_hs, 18);

    // Following frame must still use defaults: the discarded H_ACT=5 write is gone.
    clear_stats();
    ticks(72);
    check("r1_end_hcnt", hcnt, 11);
    check("r1_end_vcnt", vcnt, 5);
    check("r1_de_cnt", n_de, 12);
    check("r1_hs_cnt", n_hs, 18);
    check("r1_fs_cnt", n_fs, 1);
    check("r1_ls_cnt", n_ls, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/video_timing_sched.md
Name: video_timing_sched

Overview:
- Programmable raster timing scheduler; owns the horizontal (pixel) and vertical (line) counters.
- Sequences the sync/blank phases that the sync-generator state machine and downstream video datapath consume.
- Emits hsync, vsync, composite sync, blanking, data-enable and frame/line strobes.
- Host-writable timing registers are double-buffered and take effect only at frame boundaries, so timing never glitches mid-frame.

Parameters:
CW, 12, width of all timing fields and counters
H_ACT_D, 640, reset value of horizontal active pixels
H_FP_D, 16, reset value of horizontal front porch
H_SYNC_D, 96, reset value of horizontal sync width
H_BP_D, 48, reset value of horizontal back porch
V_ACT_D, 480, reset value of vertical active lines
V_FP_D, 10, reset value of vertical front porch
V_SYNC_D, 2, reset value of vertical sync width
V_BP_D, 33, reset value of vertical back porch

Ports:
CK  in  1  clock, rising edge
RST_N  in  1  reset, synchronous, active-low
en  in  1  count enable (pixel clock enable)
cfg_wr  in  1  write strobe for shadow timing register
cfg_addr  in  3  0..7 = H_ACT,H_FP,H_SYNC,H_BP,V_ACT,V_FP,V_SYNC,V_BP
cfg_data  in  CW  write data
cfg_pending  out  1  shadow differs from active set, awaiting frame boundary
hcnt  out  CW  pixel index of presented position
vcnt  out  CW  line index of presented position
hsync  out  1  active-high horizontal sync
vsync  out  1  active-high vertical sync
csync  out  1  composite sync = hsync XOR vsync
hblank  out  1  outside horizontal active region
vblank  out  1  outside vertical active region
de  out  1  data enable = !hblank & !vblank
line_start  out  1  one-cycle pulse at hcnt==0
frame_start  out  1  one-cycle pulse at hcnt==0 & vcnt==0

Behaviour:
- One clock (CK) only. Reset is synchronous and active-low on RST_N; all registers update on CK rising edge.
- Reset:
  - Internal position is (0,0); vertical FSM is V_ACT.
  - Active and shadow registers load the *_D defaults.
  - All outputs are 0, including cfg_pending, hcnt and vcnt.
- Latency: all outputs are registered and present the internal position with 1-cycle lag.
  - The first cycle with en=1 after reset presents (0,0): de=1, line_start=1, frame_start=1.
- Field values of 0 in any active timing register are treated as 1, so no phase is ever skipped.
- HTOT = H_ACT+H_FP+H_SYNC+H_BP, computed CW+2 bits wide.
  - hcnt wraps from HTOT-1 to 0; vcnt increments on that wrap.
- Horizontal decode:
  - hblank = hcnt >= H_ACT.
  - hsync = H_ACT+H_FP <= hcnt < H_ACT+H_FP+H_SYNC.
- Vertical FSM: V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT.
  - A per-phase line counter advances only at end-of-line; the FSM leaves a phase when that counter reaches the phase length minus 1 at end-of-line.
  - vblank = state != V_ACT.
  - vsync = state == V_SYNC; vsync is asserted for whole lines, aligned to hcnt==0.
  - vcnt resets to 0 on V_BP -> V_ACT.
- en=0: position, FSM and all outputs hold; strobes do not repeat.
- Configuration writes:
  - cfg_wr writes the shadow register at cfg_addr. Active timing is never altered.
  - cfg_pending goes to 1 the cycle after the write.
  - Shadow copies to active on the frame-end cycle (last pixel of last V_BP line, with en=1). cfg_pending clears in the same cycle.
  - A write coinciding with the frame-end cycle is not applied in that transfer: it is captured in the shadow and applied at the following frame end, and cfg_pending stays 1.
  - Writes with en=0 are still accepted.
- Reset asserted mid-frame: next cycle returns to the reset state; shadow writes are discarded.

Optional Feature:
- Macro VTG_FRAME_CNT_EN.
- Defined: extra output port frame_cnt (8 bits).
  - Reset value 0.
  - Increments, wrapping 255 -> 0, in the cycle frame_start is presented, except the first frame after reset.
- Undefined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Small config, written after reset then one frame elapsed: H=4,1,2,1 (HTOT 8); V=3,1,1,1 (VTOT 6). -> hsync high at hcnt 5,6; hblank at hcnt 4..7; vsync for all of line 4; de count is 12 per 48-cycle frame; frame_start every 48 cycles.
- Reset release with en=1 -> first output cycle hcnt=0, vcnt=0, de=1, frame_start=1, line_start=1.
- Write H_SYNC=3 mid-frame -> cfg_pending=1 the next cycle; old hsync width 2 persists to frame end; width 3 from the next frame; cfg_pending clears at frame end.
- Write V_FP=0 -> front porch lasts exactly 1 line; VTOT remains 6.
- Toggle en low for 5 cycles at hcnt=3 -> all outputs frozen; hcnt resumes at 4; exactly one line_start per line.
- Assert RST_N=0 at vcnt=4 (V_SYNC) -> next cycle vsync=0, hcnt=0; shadow reverts to defaults; cfg_pending=0.
